// File: rtl/axis_i2c_writer.sv
// axis_i2c_writer: buffers AXIS words in a sync FIFO and writes each one to a fixed I2C
// slave as address byte plus MSB-first data bytes, one START/STOP per word.
module axis_i2c_writer #(
    parameter int          AXIS_DATA_WIDTH = 16,
    parameter int          FIFO_DEPTH      = 16,
    parameter int          CLK_DIV         = 250,
    parameter logic [6:0]  SLAVE_ADDR      = 7'h50
) (
    input  logic                              clk,
    input  logic                              arst,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic [AXIS_DATA_WIDTH-1:0]        s_axis_tdata,
    output logic                              scl_o,
    output logic                              sda_o,
    input  logic                              sda_i,
    input  logic                              nack_clr,
    output logic                              busy,
    output logic                              nack_err,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int NB = AXIS_DATA_WIDTH / 8;
    localparam int SW = AXIS_DATA_WIDTH + 8;
    localparam int CW = $clog2(CLK_DIV);

    typedef enum logic [2:0] {IDLE, START, ADDR, DATA, ACK, STOP} state_t;

    state_t                     state, state_n;
    logic [AXIS_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]              wr_ptr, rd_ptr;
    logic [LW-1:0]              level;
    logic [CW-1:0]              cnt;
    logic [1:0]                 q;
    logic [2:0]                 bit_cnt;
    logic [3:0]                 byte_cnt;
    logic [SW-1:0]              sr;
    logic                       push, pop, tick, slot_end, nack_s, nack_set;

    assign s_axis_tready = level != LW'(FIFO_DEPTH);
    assign push          = s_axis_tvalid && s_axis_tready;
    assign fifo_level    = level;
    assign busy          = state != IDLE;
    assign tick          = cnt == CW'(CLK_DIV - 1);
    assign slot_end      = tick && q == 2'd3;

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= s_axis_tdata;

    always_ff @(posedge clk or posedge arst)
        if (arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            level  <= level + LW'(push) - LW'(pop);
        end

    always_ff @(posedge clk or posedge arst)
        if (arst) state <= IDLE;
        else      state <= state_n;

    always_comb begin
        state_n  = state;
        pop      = 1'b0;
        scl_o    = 1'b1;
        sda_o    = 1'b1;
        nack_set = 1'b0;
        case (state)
            IDLE: begin
                pop     = level != '0;
                state_n = pop ? START : IDLE;
            end
            START: begin
                sda_o   = !q[1];
                state_n = slot_end ? ADDR : START;
            end
            ADDR, DATA: begin
                scl_o   = q[1];
                sda_o   = sr[SW-1];
                state_n = (slot_end && bit_cnt == 3'd7) ? ACK : state;
            end
            ACK: begin
                scl_o    = q[1];
                nack_set = slot_end && nack_s;
                state_n  = !slot_end ? ACK : (nack_s || byte_cnt == 4'(NB)) ? STOP : DATA;
            end
            STOP: begin
                scl_o   = q[1];
                sda_o   = q == 2'd3;
                state_n = slot_end ? IDLE : STOP;
            end
            default: state_n = IDLE;
        endcase
    end

    // Divider and quarter counter idle at zero so every word starts on a clean slot.
    always_ff @(posedge clk or posedge arst)
        if (arst) begin
            cnt      <= '0;
            q        <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            sr       <= '0;
            nack_s   <= 1'b0;
            nack_err <= 1'b0;
        end else begin
            cnt <= (state == IDLE || tick) ? '0 : cnt + 1'b1;
            q   <= state == IDLE ? 2'd0 : tick ? q + 2'd1 : q;
            if (pop) begin
                sr       <= {SLAVE_ADDR, 1'b0, mem[rd_ptr]};
                bit_cnt  <= '0;
                byte_cnt <= '0;
            end else if (slot_end && (state == ADDR || state == DATA)) begin
                sr      <= sr << 1;
                bit_cnt <= bit_cnt + 3'd1;
            end else if (slot_end && state == ACK && state_n == DATA) begin
                byte_cnt <= byte_cnt + 4'd1;
            end
            if (tick && q == 2'd2 && state == ACK) nack_s <= sda_i;
            nack_err <= nack_set || (nack_err && !nack_clr);
        end
endmodule
